// File: rtl/proc_pkg.sv
// Shared definitions for the boot loader and the HD-side helpers:
// write-port control codes, loader state encodings and memory depth.
package proc_pkg;

   localparam logic [2:0]  CTRL_SEM_ESCRITA = 3'b000;
   localparam logic [2:0]  CTRL_ESCREVE     = 3'b001;
   localparam int unsigned MEM_DEPTH_PADRAO = 201;

   typedef enum logic [2:0] {
      EST_IDLE  = 3'd0,
      EST_CHECK = 3'd1,
      EST_REQ   = 3'd2,
      EST_WRITE = 3'd3,
      EST_FIM   = 3'd4,
      EST_ERRO  = 3'd5
   } estado_t;

endpackage

// File: rtl/contador_timeout.sv
// Up-counting wait timer; estourou flags the TIMEOUT-th enabled cycle so the
// owner can abandon the wait on that same edge.
module contador_timeout #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic estourou
);

   localparam int unsigned        LARGURA = $clog2(TIMEOUT + 1);
   localparam logic [LARGURA-1:0] LIMITE  = LARGURA'(TIMEOUT - 1);

   logic [LARGURA-1:0] cnt_q, cnt_d;

   assign estourou = enable && (cnt_q == LIMITE);

   // Saturates at the limit so a caller that keeps waiting sees a steady flag.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !estourou) begin
         cnt_d = cnt_q + LARGURA'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/carregador_instrucoes.sv
// Boot-time loader: copies numWords words from the HD into instruction memory
// while stalling the CPU, then publishes the start PC.
//
//   state | meaning
//   IDLE  | waiting for start, parameters free to change
//   CHECK | range check of the latched block
//   REQ   | read request held until hdAck or timeout
//   WRITE | one-cycle write of the captured word
//   FIM   | load complete, done/pcInicial follow next cycle
//   ERRO  | range or timeout failure, erro follows next cycle
module carregador_instrucoes
   import proc_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = MEM_DEPTH_PADRAO,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] hdBase,
   input  logic [31:0] memBase,
   input  logic [10:0] numWords,
   output logic        hdReq,
   output logic [31:0] hdAddr,
   input  logic        hdAck,
   input  logic [31:0] hdData,
   output logic [31:0] entradaDeInstrucao,
   output logic [31:0] posicaoParaSalvarInstrucao,
   output logic [2:0]  controleSalvaInstrucao,
   output logic        cpuHold,
   output logic        busy,
   output logic        done,
   output logic        erro,
   output logic [31:0] pcInicial
);

   estado_t     estado_q, estado_d;
   logic [31:0] hd_base_q, hd_base_d, mem_base_q, mem_base_d, dado_q, dado_d;
   logic [10:0] num_words_q, num_words_d, count_q, count_d;

   logic        hd_req_q, hd_req_d, busy_q, busy_d, done_q, done_d, erro_q, erro_d;
   logic [31:0] hd_addr_q, hd_addr_d, entrada_q, entrada_d, posicao_q, posicao_d;
   logic [31:0] pc_q, pc_d;
   logic [2:0]  ctrl_q, ctrl_d;

   logic        estourou;
   logic [32:0] soma_faixa;

   contador_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clock    (clock),
      .reset    (reset),
      .clear    ((estado_q != EST_REQ) || hdAck),
      .enable   (estado_q == EST_REQ),
      .estourou (estourou)
   );

   assign soma_faixa = {1'b0, mem_base_q} + {22'd0, num_words_q};

   always_comb begin
      estado_d    = estado_q;
      hd_base_d   = hd_base_q;
      mem_base_d  = mem_base_q;
      num_words_d = num_words_q;
      count_d     = count_q;
      dado_d      = dado_q;
      hd_req_d    = 1'b0;
      hd_addr_d   = '0;
      entrada_d   = '0;
      posicao_d   = '0;
      ctrl_d      = CTRL_SEM_ESCRITA;
      // Completion flags trail FIM/ERRO by one cycle, landing with busy low.
      done_d      = (estado_q == EST_FIM);
      erro_d      = (estado_q == EST_ERRO);
      pc_d        = (estado_q == EST_FIM) ? mem_base_q : pc_q;

      unique case (estado_q)
         EST_IDLE: begin
            if (start) begin
               hd_base_d   = hdBase;
               mem_base_d  = memBase;
               num_words_d = numWords;
               count_d     = '0;
               estado_d    = EST_CHECK;
            end
         end
         EST_CHECK: begin
            if (num_words_q == '0) begin
               estado_d = EST_FIM;
            end else if (soma_faixa > 33'(MEM_DEPTH)) begin
               estado_d = EST_ERRO;
            end else begin
               estado_d = EST_REQ;
            end
         end
         EST_REQ: begin
            if (hdAck) begin
               dado_d   = hdData;
               estado_d = EST_WRITE;
            end else if (estourou) begin
               estado_d = EST_ERRO;
            end
         end
         EST_WRITE: begin
            count_d  = count_q + 11'd1;
            estado_d = ({1'b0, count_q} + 12'd1 == {1'b0, num_words_q}) ? EST_FIM : EST_REQ;
         end
         EST_FIM:  estado_d = EST_IDLE;
         EST_ERRO: estado_d = EST_IDLE;
         default:  estado_d = EST_IDLE;
      endcase

      busy_d = (estado_d != EST_IDLE);
      if (estado_d == EST_REQ) begin
         hd_req_d  = 1'b1;
         hd_addr_d = hd_base_q + 32'(count_d);
      end
      if (estado_d == EST_WRITE) begin
         ctrl_d    = CTRL_ESCREVE;
         posicao_d = mem_base_q + 32'(count_d);
         entrada_d = dado_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q    <= EST_IDLE;
         hd_base_q   <= '0;
         mem_base_q  <= '0;
         num_words_q <= '0;
         count_q     <= '0;
         dado_q      <= '0;
         hd_req_q    <= 1'b0;
         hd_addr_q   <= '0;
         entrada_q   <= '0;
         posicao_q   <= '0;
         ctrl_q      <= CTRL_SEM_ESCRITA;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         erro_q      <= 1'b0;
         pc_q        <= '0;
      end else begin
         estado_q    <= estado_d;
         hd_base_q   <= hd_base_d;
         mem_base_q  <= mem_base_d;
         num_words_q <= num_words_d;
         count_q     <= count_d;
         dado_q      <= dado_d;
         hd_req_q    <= hd_req_d;
         hd_addr_q   <= hd_addr_d;
         entrada_q   <= entrada_d;
         posicao_q   <= posicao_d;
         ctrl_q      <= ctrl_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         erro_q      <= erro_d;
         pc_q        <= pc_d;
      end
   end

   assign hdReq                      = hd_req_q;
   assign hdAddr                     = hd_addr_q;
   assign entradaDeInstrucao         = entrada_q;
   assign posicaoParaSalvarInstrucao = posicao_q;
   assign controleSalvaInstrucao     = ctrl_q;
   assign busy                       = busy_q;
   assign cpuHold                    = busy_q;
   assign done                       = done_q;
   assign erro                       = erro_q;
   assign pcInicial                  = pc_q;

endmodule
